// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: decodes the ID word into ALU op S, selects SrcA/SrcB and registers EX controls; MUL_EN enables mul.
// Latency: 1 cycle from ID inputs to ex_* outputs.
// Backpressure: stall holds the EX register, flush loads a bubble (flush wins over stall).
module alu_issue_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [31:0]       id_instr,
    input  logic [DATA_W-1:0] id_rd1,
    input  logic [DATA_W-1:0] id_rd2,
    input  logic              stall,
    input  logic              flush,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_SrcA,
    output logic [DATA_W-1:0] ex_SrcB,
    output logic [2:0]        ex_S,
    output logic [DATA_W-1:0] ex_writedata,
    output logic [REG_AW-1:0] ex_writereg,
    output logic              ex_regwrite,
    output logic              ex_memwrite,
    output logic              ex_memtoreg,
    output logic              ex_branch,
    output logic              illegal_seen
);

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b110;
`ifdef MUL_EN
    localparam logic [2:0] ALU_MUL = 3'b101;
`endif

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_SPEC2 = 6'b011100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
`ifdef MUL_EN
    localparam logic [5:0] FN_MUL = 6'b000010;
`endif

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] srca;
        logic [DATA_W-1:0] srcb;
        logic [2:0]        s;
        logic [DATA_W-1:0] wdata;
        logic [REG_AW-1:0] wreg;
        logic              regwrite;
        logic              memwrite;
        logic              memtoreg;
        logic              branch;
    } ex_reg_t;

    ex_reg_t ex_q, ex_d, dec;
    logic    dec_legal;
    logic    illegal_seen_q, illegal_seen_d;

    logic [5:0]        opcode, funct;
    logic [15:0]       imm;
    logic [DATA_W-1:0] imm_sext, imm_zext;
    logic [REG_AW-1:0] rt_addr, rd_addr;
    // rs and shamt are not needed: rs data arrives already read on id_rd1.
    logic              unused_instr_bits;

    assign opcode   = id_instr[31:26];
    assign funct    = id_instr[5:0];
    assign imm      = id_instr[15:0];
    assign imm_sext = {{(DATA_W-16){imm[15]}}, imm};
    assign imm_zext = {{(DATA_W-16){1'b0}}, imm};
    assign rt_addr  = REG_AW'(id_instr[20:16]);
    assign rd_addr  = REG_AW'(id_instr[15:11]);
    assign unused_instr_bits = ^{id_instr[25:21], id_instr[10:6]};

    always_comb begin
        dec       = '0;
        dec_legal = 1'b0;
        unique case (opcode)
            OP_RTYPE: begin
                dec.srcb     = id_rd2;
                dec.regwrite = 1'b1;
                dec.wreg     = rd_addr;
                dec_legal    = 1'b1;
                unique case (funct)
                    FN_ADD:  dec.s = ALU_ADD;
                    FN_SUB:  dec.s = ALU_SUB;
                    FN_AND:  dec.s = ALU_AND;
                    FN_OR:   dec.s = ALU_OR;
                    FN_SLT:  dec.s = ALU_SLT;
                    default: dec_legal = 1'b0;
                endcase
            end
`ifdef MUL_EN
            OP_SPEC2: begin
                if (funct == FN_MUL) begin
                    dec.s        = ALU_MUL;
                    dec.srcb     = id_rd2;
                    dec.regwrite = 1'b1;
                    dec.wreg     = rd_addr;
                    dec_legal    = 1'b1;
                end
            end
`else
            OP_SPEC2: dec_legal = 1'b0;
`endif
            OP_ADDI, OP_SLTI: begin
                dec.s        = (opcode == OP_ADDI) ? ALU_ADD : ALU_SLT;
                dec.srcb     = imm_sext;
                dec.regwrite = 1'b1;
                dec.wreg     = rt_addr;
                dec_legal    = 1'b1;
            end
            OP_ANDI, OP_ORI: begin
                dec.s        = (opcode == OP_ANDI) ? ALU_AND : ALU_OR;
                dec.srcb     = imm_zext;
                dec.regwrite = 1'b1;
                dec.wreg     = rt_addr;
                dec_legal    = 1'b1;
            end
            OP_LW: begin
                dec.s        = ALU_ADD;
                dec.srcb     = imm_sext;
                dec.regwrite = 1'b1;
                dec.memtoreg = 1'b1;
                dec.wreg     = rt_addr;
                dec_legal    = 1'b1;
            end
            OP_SW: begin
                dec.s        = ALU_ADD;
                dec.srcb     = imm_sext;
                dec.memwrite = 1'b1;
                dec.wdata    = id_rd2;
                dec_legal    = 1'b1;
            end
            OP_BEQ: begin
                dec.s      = ALU_SUB;
                dec.srcb   = id_rd2;
                dec.branch = 1'b1;
                dec_legal  = 1'b1;
            end
            default: dec_legal = 1'b0;
        endcase
        dec.valid = dec_legal;
        dec.srca  = dec_legal ? id_rd1 : '0;
        // $0 is hardwired zero, so a write to it is dropped here rather than in WB.
        if (dec.wreg == '0) begin
            dec.regwrite = 1'b0;
        end
    end

    always_comb begin
        ex_d           = ex_q;
        illegal_seen_d = illegal_seen_q;
        if (flush) begin
            ex_d = '0;
        end else if (!stall) begin
            if (!id_valid) begin
                ex_d = '0;
            end else if (dec_legal) begin
                ex_d = dec;
            end else begin
                // Keep the slot visibly occupied so the trap is attributable downstream.
                ex_d           = '0;
                ex_d.valid     = 1'b1;
                illegal_seen_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q           <= '0;
            illegal_seen_q <= 1'b0;
        end else begin
            ex_q           <= ex_d;
            illegal_seen_q <= illegal_seen_d;
        end
    end

    assign ex_valid     = ex_q.valid;
    assign ex_SrcA      = ex_q.srca;
    assign ex_SrcB      = ex_q.srcb;
    assign ex_S         = ex_q.s;
    assign ex_writedata = ex_q.wdata;
    assign ex_writereg  = ex_q.wreg;
    assign ex_regwrite  = ex_q.regwrite;
    assign ex_memwrite  = ex_q.memwrite;
    assign ex_memtoreg  = ex_q.memtoreg;
    assign ex_branch    = ex_q.branch;
    assign illegal_seen = illegal_seen_q;

endmodule
